// File: rtl/vn_iter_update_ctrl_pkg.sv
// Shared VN decoding-control constants: iteration/page geometry, ROM latency and the
// iteration-update FSM encoding.
package vn_iter_update_ctrl_pkg;

  localparam int VN_ITER_NUM = 25;
  localparam int VN_PAGE_NUM = 64;
  localparam int VN_ROM_LAT  = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } vn_upd_state_t;

endpackage

// File: rtl/vn_we_align_pipe.sv
// Valid shift register (DEPTH deep) aligning the IB-RAM write enable with latch output data.
// Latency DEPTH cycles; no backpressure, it always shifts.
module vn_we_align_pipe #(
  parameter int DEPTH = 2
) (
  input  logic write_clk,
  input  logic rstn,
  input  logic fetch_vld,
  output logic we
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      sr <= '0;
    end else begin
      sr <= (sr << 1) | DEPTH'(fetch_vld);
    end
  end

  assign we = sr[DEPTH-1];

endmodule

// File: rtl/vn_iter_update_ctrl.sv
// Sequences one IB-ROM page sweep into vn_mem_latch and the aligned IB-RAM write port.
// Request to update_done is PAGE_NUM+ROM_LAT+3 cycles; requests while busy are rejected via req_err.
module vn_iter_update_ctrl
  import vn_iter_update_ctrl_pkg::*;
#(
  parameter int ITER_ADDR_BW = 5,
  parameter int ITER_NUM     = VN_ITER_NUM,
  parameter int PAGE_ADDR_BW = 6,
  parameter int PAGE_NUM     = VN_PAGE_NUM,
  parameter int ROM_LAT      = VN_ROM_LAT
) (
  input  logic                    write_clk,
  input  logic                    rstn,
  input  logic                    iter_update_req,
  input  logic [ITER_ADDR_BW-1:0] iter_target,
  output logic [ITER_ADDR_BW-1:0] latch_iter,
  output logic                    rom_port_fetch,
  output logic                    ram_we,
  output logic [PAGE_ADDR_BW-1:0] ram_waddr,
  output logic                    busy,
  output logic                    update_done,
  output logic                    req_err
);

  localparam int FCNT_BW = $clog2(PAGE_NUM + 1);
  localparam int DCNT_BW = 3;
  localparam logic [FCNT_BW-1:0] FETCH_LAST = FCNT_BW'(PAGE_NUM - 1);
  localparam logic [DCNT_BW-1:0] DRAIN_LAST = DCNT_BW'(ROM_LAT);

  vn_upd_state_t      state_q, state_d;
  logic [FCNT_BW-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [DCNT_BW-1:0] drain_cnt_q, drain_cnt_d;
  logic               target_ok;
  logic               accept;
  logic               reject;
  logic               err_pend_q;
  logic               fetch_vld;

  assign target_ok = {1'b0, iter_target} < (ITER_ADDR_BW + 1)'(ITER_NUM);
  assign fetch_vld = (state_q == ST_FETCH);

  always_comb begin
    state_d     = state_q;
    fetch_cnt_d = fetch_cnt_q;
    drain_cnt_d = drain_cnt_q;
    accept      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iter_update_req && target_ok) begin
          accept  = 1'b1;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        state_d     = ST_FETCH;
        fetch_cnt_d = '0;
      end
      ST_FETCH: begin
        if (fetch_cnt_q == FETCH_LAST) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end else begin
          fetch_cnt_d = fetch_cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    reject = iter_update_req && !accept;
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ST_IDLE;
      fetch_cnt_q    <= '0;
      drain_cnt_q    <= '0;
      latch_iter     <= '0;
      rom_port_fetch <= 1'b0;
      busy           <= 1'b0;
      update_done    <= 1'b0;
      req_err        <= 1'b0;
      err_pend_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      fetch_cnt_q    <= fetch_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      if (accept) begin
        latch_iter <= iter_target;
      end
      rom_port_fetch <= state_d inside {ST_FETCH, ST_DRAIN, ST_DONE};
      busy           <= (state_d != ST_IDLE);
      update_done    <= (state_d == ST_DONE);
      // A rejection that would land on the update_done cycle is held back by one cycle.
      if (state_d == ST_DONE) begin
        req_err    <= 1'b0;
        err_pend_q <= reject;
      end else begin
        req_err    <= reject | err_pend_q;
        err_pend_q <= 1'b0;
      end
    end
  end

  vn_we_align_pipe #(
    .DEPTH (ROM_LAT + 1)
  ) u_we_align (
    .write_clk (write_clk),
    .rstn      (rstn),
    .fetch_vld (fetch_vld),
    .we        (ram_we)
  );

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      ram_waddr <= '0;
    end else if (state_q == ST_IDLE) begin
      ram_waddr <= '0;
    end else if (ram_we) begin
      ram_waddr <= ram_waddr + 1'b1;
    end
  end

endmodule

// File: tb/tb_vn_iter_update_ctrl.sv
// Directed bench: default build (ROM_LAT=1) and a ROM_LAT=3 build, with a latch+ROM data model.
module tb_vn_iter_update_ctrl;

  localparam int IW = 5;
  localparam int PW = 6;

  logic          write_clk = 1'b0;
  logic          rstn;
  logic          req;
  logic [IW-1:0] tgt;
  logic          sel;

  always #5 write_clk = ~write_clk;

  logic          req_a, req_b;
  logic [IW-1:0] li_a, li_b;
  logic          rpf_a, rpf_b, we_a, we_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [PW-1:0] wa_a, wa_b;

  assign req_a = req & ~sel;
  assign req_b = req & sel;

  vn_iter_update_ctrl u_dut_a (
    .write_clk(write_clk), .rstn(rstn), .iter_update_req(req_a), .iter_target(tgt),
    .latch_iter(li_a), .rom_port_fetch(rpf_a), .ram_we(we_a), .ram_waddr(wa_a),
    .busy(busy_a), .update_done(done_a), .req_err(err_a));

  vn_iter_update_ctrl #(.ROM_LAT(3)) u_dut_b (
    .write_clk(write_clk), .rstn(rstn), .iter_update_req(req_b), .iter_target(tgt),
    .latch_iter(li_b), .rom_port_fetch(rpf_b), .ram_we(we_b), .ram_waddr(wa_b),
    .busy(busy_b), .update_done(done_b), .req_err(err_b));

  function automatic logic [15:0] rom_word(input logic [IW+PW-1:0] a);
    logic [15:0] t;
    t = {5'd0, a};
    return (t * 16'd37 + 16'd11) ^ 16'h5a5a;
  endfunction

  // vn_mem_latch model: page counter held at 0 while rom_port_fetch is low, then ROM + latch pipe
  logic [PW-1:0]    pg_a, pg_b;
  logic [IW+PW-1:0] pipe_a [0:3];
  logic [IW+PW-1:0] pipe_b [0:3];

  always @(posedge write_clk or negedge rpf_a)
    if (!rpf_a) pg_a <= '0; else pg_a <= pg_a + 1'b1;
  always @(posedge write_clk or negedge rpf_b)
    if (!rpf_b) pg_b <= '0; else pg_b <= pg_b + 1'b1;

  always @(posedge write_clk) begin
    pipe_a[0] <= {li_a, pg_a};
    pipe_b[0] <= {li_b, pg_b};
    for (int i = 1; i < 4; i++) begin
      pipe_a[i] <= pipe_a[i-1];
      pipe_b[i] <= pipe_b[i-1];
    end
  end

  logic [15:0]   m_dat;
  logic [IW-1:0] m_li;
  logic [PW-1:0] m_wa;
  logic          m_rpf, m_we, m_busy, m_done, m_err;

  assign m_dat  = sel ? rom_word(pipe_b[3]) : rom_word(pipe_a[1]);
  assign m_li   = sel ? li_b : li_a;
  assign m_wa   = sel ? wa_b : wa_a;
  assign m_rpf  = sel ? rpf_b : rpf_a;
  assign m_we   = sel ? we_b : we_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_done = sel ? done_b : done_a;
  assign m_err  = sel ? err_b : err_a;

  int n_checks = 0;
  int n_fail   = 0;

  int fetch_k, we_k, we_last, we_cnt, wr_in_sweep, waddr_bad, data_bad;
  int done_k, done_cnt, err_k, err_cnt, both, busy_seen, busy_after, busy_last;
  int rst_nz, rst_samples;
  logic [IW-1:0] li_done, li_last;

  // k counts clock edges after the one that launches the request
  task automatic observe(input int ncyc, input logic [IW-1:0] t0, input int k1,
                         input logic [IW-1:0] t1, input int rst_k);
    fetch_k = -1; we_k = -1; we_last = -1; we_cnt = 0; wr_in_sweep = 0;
    waddr_bad = 0; data_bad = 0; done_k = -10; done_cnt = 0; err_k = -1; err_cnt = 0;
    both = 0; busy_seen = 0; busy_after = -1; busy_last = -1; rst_nz = 0; rst_samples = 0;
    li_done = '1; li_last = '1;
    @(posedge write_clk); #1;
    req = 1'b1; tgt = t0;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge write_clk); #1;
      req = (k == k1);
      if (k == k1) tgt = t1;
      if (k == rst_k) rstn = 1'b0;
      if (k == rst_k + 3) rstn = 1'b1;
      @(negedge write_clk);
      if (!rstn) begin
        rst_samples++;
        if ({m_li, m_rpf, m_we, m_wa, m_busy, m_done, m_err} != '0) rst_nz++;
      end
      if (m_rpf && fetch_k < 0) fetch_k = k;
      if (m_we) begin
        if (we_k < 0) we_k = k;
        we_last = k;
        if (m_wa !== PW'(wr_in_sweep)) waddr_bad++;
        if (m_dat !== rom_word({m_li, m_wa})) data_bad++;
        wr_in_sweep++;
        we_cnt++;
      end
      if (k == done_k + 1) busy_after = int'(m_busy);
      if (m_done) begin
        done_cnt++; done_k = k; wr_in_sweep = 0; li_done = m_li;
        if (m_err) both++;
      end
      if (m_err) begin err_cnt++; err_k = k; end
      if (m_busy) busy_seen = 1;
      busy_last = int'(m_busy);
      li_last = m_li;
    end
    req = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req = 1'b0; tgt = '0; sel = 1'b0;
    repeat (3) @(posedge write_clk);
    @(negedge write_clk);
    n_checks++; if ({li_a, rpf_a, we_a, wa_a, busy_a, done_a, err_a} !== '0) begin n_fail++; $display("FAIL reset_outputs_a: got %h want 0", {li_a, rpf_a, we_a, wa_a, busy_a, done_a, err_a}); end
    n_checks++; if ({li_b, rpf_b, we_b, wa_b, busy_b, done_b, err_b} !== '0) begin n_fail++; $display("FAIL reset_outputs_b: got %h want 0", {li_b, rpf_b, we_b, wa_b, busy_b, done_b, err_b}); end
    @(posedge write_clk); #1 rstn = 1'b1;
    repeat (2) @(posedge write_clk);
  endtask

  task automatic test_basic_sweep();
    sel = 1'b0;
    observe(75, 5'd3, -1, 5'd0, -1);
    n_checks++; if (fetch_k !== 2) begin n_fail++; $display("FAIL basic_fetch_rise: got %0d want 2", fetch_k); end
    n_checks++; if (we_k !== 4) begin n_fail++; $display("FAIL basic_we_first: got %0d want 4", we_k); end
    n_checks++; if (we_last !== 67) begin n_fail++; $display("FAIL basic_we_last: got %0d want 67", we_last); end
    n_checks++; if (we_cnt !== 64) begin n_fail++; $display("FAIL basic_we_count: got %0d want 64", we_cnt); end
    n_checks++; if (waddr_bad !== 0) begin n_fail++; $display("FAIL basic_waddr_seq: got %0d bad want 0", waddr_bad); end
    n_checks++; if (data_bad !== 0) begin n_fail++; $display("FAIL basic_data: got %0d bad want 0", data_bad); end
    n_checks++; if (done_k !== 68) begin n_fail++; $display("FAIL basic_done_latency: got %0d want 68", done_k); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    n_checks++; if (busy_after !== 0) begin n_fail++; $display("FAIL basic_busy_after_done: got %0d want 0", busy_after); end
    n_checks++; if (li_done !== 5'd3) begin n_fail++; $display("FAIL basic_latch_iter: got %0d want 3", li_done); end
    n_checks++; if (err_cnt !== 0) begin n_fail++; $display("FAIL basic_no_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_busy_reject();
    sel = 1'b0;
    observe(75, 5'd7, 10, 5'd5, -1);
    n_checks++; if (err_cnt !== 1) begin n_fail++; $display("FAIL busy_err_count: got %0d want 1", err_cnt); end
    n_checks++; if (err_k !== 11) begin n_fail++; $display("FAIL busy_err_cycle: got %0d want 11", err_k); end
    n_checks++; if (we_cnt !== 64) begin n_fail++; $display("FAIL busy_we_count: got %0d want 64", we_cnt); end
    n_checks++; if (done_k !== 68) begin n_fail++; $display("FAIL busy_done_latency: got %0d want 68", done_k); end
    n_checks++; if (li_done !== 5'd7) begin n_fail++; $display("FAIL busy_latch_iter: got %0d want 7", li_done); end
    n_checks++; if (data_bad !== 0) begin n_fail++; $display("FAIL busy_data: got %0d bad want 0", data_bad); end
  endtask

  task automatic test_bad_target();
    sel = 1'b0;
    observe(8, 5'd25, -1, 5'd0, -1);
    n_checks++; if (err_cnt !== 1) begin n_fail++; $display("FAIL badtgt_err_count: got %0d want 1", err_cnt); end
    n_checks++; if (err_k !== 1) begin n_fail++; $display("FAIL badtgt_err_cycle: got %0d want 1", err_k); end
    n_checks++; if (busy_seen !== 0) begin n_fail++; $display("FAIL badtgt_busy: got %0d want 0", busy_seen); end
    n_checks++; if (fetch_k !== -1) begin n_fail++; $display("FAIL badtgt_fetch: got %0d want -1", fetch_k); end
    n_checks++; if (li_last !== 5'd7) begin n_fail++; $display("FAIL badtgt_latch_iter: got %0d want 7", li_last); end
  endtask

  task automatic test_req_at_done();
    sel = 1'b0;
    observe(75, 5'd9, 67, 5'd2, -1);
    n_checks++; if (err_cnt !== 1) begin n_fail++; $display("FAIL atdone_err_count: got %0d want 1", err_cnt); end
    n_checks++; if (err_k !== 69) begin n_fail++; $display("FAIL atdone_err_cycle: got %0d want 69", err_k); end
    n_checks++; if (both !== 0) begin n_fail++; $display("FAIL atdone_err_with_done: got %0d want 0", both); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL atdone_done_count: got %0d want 1", done_cnt); end
    n_checks++; if (busy_last !== 0) begin n_fail++; $display("FAIL atdone_no_restart: got %0d want 0", busy_last); end
    n_checks++; if (li_last !== 5'd9) begin n_fail++; $display("FAIL atdone_latch_iter: got %0d want 9", li_last); end
  endtask

  task automatic test_reset_mid_sweep();
    sel = 1'b0;
    observe(30, 5'd11, -1, 5'd0, 22);
    n_checks++; if (rst_samples !== 3) begin n_fail++; $display("FAIL midrst_samples: got %0d want 3", rst_samples); end
    n_checks++; if (rst_nz !== 0) begin n_fail++; $display("FAIL midrst_outputs_zero: got %0d nonzero want 0", rst_nz); end
    n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d want 0", done_cnt); end
    n_checks++; if (busy_last !== 0) begin n_fail++; $display("FAIL midrst_idle: got %0d want 0", busy_last); end
    observe(75, 5'd24, -1, 5'd0, -1);
    n_checks++; if (we_cnt !== 64) begin n_fail++; $display("FAIL postrst_we_count: got %0d want 64", we_cnt); end
    n_checks++; if (waddr_bad !== 0) begin n_fail++; $display("FAIL postrst_waddr_seq: got %0d bad want 0", waddr_bad); end
    n_checks++; if (data_bad !== 0) begin n_fail++; $display("FAIL postrst_data: got %0d bad want 0", data_bad); end
    n_checks++; if (done_k !== 68) begin n_fail++; $display("FAIL postrst_done_latency: got %0d want 68", done_k); end
    n_checks++; if (li_done !== 5'd24) begin n_fail++; $display("FAIL postrst_latch_iter: got %0d want 24", li_done); end
  endtask

  task automatic test_back_to_back();
    sel = 1'b1;
    observe(150, 5'd1, 71, 5'd20, -1);
    n_checks++; if (fetch_k !== 2) begin n_fail++; $display("FAIL b2b_fetch_rise: got %0d want 2", fetch_k); end
    n_checks++; if (we_k !== 6) begin n_fail++; $display("FAIL b2b_we_first: got %0d want 6", we_k); end
    n_checks++; if (we_last !== 140) begin n_fail++; $display("FAIL b2b_we_last: got %0d want 140", we_last); end
    n_checks++; if (we_cnt !== 128) begin n_fail++; $display("FAIL b2b_we_count: got %0d want 128", we_cnt); end
    n_checks++; if (done_cnt !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
    n_checks++; if (done_k !== 141) begin n_fail++; $display("FAIL b2b_done_cycle: got %0d want 141", done_k); end
    n_checks++; if (err_cnt !== 0) begin n_fail++; $display("FAIL b2b_no_err: got %0d want 0", err_cnt); end
    n_checks++; if (waddr_bad !== 0) begin n_fail++; $display("FAIL b2b_waddr_seq: got %0d bad want 0", waddr_bad); end
    n_checks++; if (data_bad !== 0) begin n_fail++; $display("FAIL b2b_data: got %0d bad want 0", data_bad); end
    n_checks++; if (li_done !== 5'd20) begin n_fail++; $display("FAIL b2b_latch_iter: got %0d want 20", li_done); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_sweep();
    test_busy_reject();
    test_bad_target();
    test_req_at_done();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
